// File: rtl/online_pkg.sv
// Shared definitions for the signed-digit online datapath: digit encoding,
// width helpers and value conversion helpers.
package online_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int wl_digits(input int n);
    return 2 * n;
  endfunction

  // Output width: input digits + coefficient digits + one digit per tree level.
  function automatic int wl_out(input int stage, input int cw);
    return wl_digits(stage + cw + clog2(cw));
  endfunction

  // Number of live operands at adder-tree level lvl (level 0 = partial products).
  function automatic int tree_cnt(input int cw, input int lvl);
    int c;
    c = cw;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // 11 is a legal redundant zero, so only the two single-bit codes carry weight.
  function automatic logic signed [2:0] digit_val(input logic [1:0] d);
    case (d)
      DIG_POS: return 3'sd1;
      DIG_NEG: return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] digit_enc(input logic signed [2:0] v);
    if (v == 3'sd1) return DIG_POS;
    if (v == -3'sd1) return DIG_NEG;
    return DIG_ZERO;
  endfunction

  // Non-adjacent-form CSD encoding of v into n digits (n <= 32).
  function automatic logic [63:0] to_csd(input longint v, input int n);
    logic [63:0] r;
    longint      m;
    r = '0;
    m = v;
    for (int i = 0; i < n && i < 32; i++) begin
      if (m[0]) begin
        if (m[1]) begin
          r[2*i +: 2] = DIG_NEG;
          m = m + 1;
        end else begin
          r[2*i +: 2] = DIG_POS;
          m = m - 1;
        end
      end
      m = m >>> 1;
    end
    return r;
  endfunction

  function automatic longint sd_value(input logic [63:0] v, input int n);
    longint r;
    r = 0;
    for (int i = 0; i < n && i < 32; i++)
      r += longint'(digit_val(v[2*i +: 2])) * (longint'(1) <<< i);
    return r;
  endfunction

endpackage

// File: rtl/online_adder.sv
// Carry-free radix-2 signed-digit adder: N digits per operand, N+1 digits out.
// Each position only looks one digit down, so the delay is independent of N.
module online_adder
  import online_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic [2*N+1:0] s
);

  logic signed [2:0] p [N];
  logic signed [2:0] t [N+1];   // t[i+1] is the transfer leaving digit i
  logic signed [2:0] w [N+1];
  logic [N:0]        lo_neg;    // lo_neg[i]: a negative operand digit at i-1

  // Position sums, transfer/interim split, then fold transfers back in.
  always_comb begin
    lo_neg = '0;
    s      = '0;
    t[0]   = 3'sd0;
    w[N]   = 3'sd0;
    for (int i = 0; i < N; i++) begin
      p[i] = digit_val(a[2*i +: 2]) + digit_val(b[2*i +: 2]);
      lo_neg[i+1] = (digit_val(a[2*i +: 2]) == -3'sd1) ||
                    (digit_val(b[2*i +: 2]) == -3'sd1);
    end
    for (int i = 0; i < N; i++) begin
      case (p[i])
        3'sd2: begin
          t[i+1] = 3'sd1;
          w[i]   = 3'sd0;
        end
        -3'sd2: begin
          t[i+1] = -3'sd1;
          w[i]   = 3'sd0;
        end
        3'sd1: begin
          t[i+1] = lo_neg[i] ? 3'sd0 : 3'sd1;
          w[i]   = lo_neg[i] ? 3'sd1 : -3'sd1;
        end
        -3'sd1: begin
          t[i+1] = lo_neg[i] ? -3'sd1 : 3'sd0;
          w[i]   = lo_neg[i] ? 3'sd1 : -3'sd1;
        end
        default: begin
          t[i+1] = 3'sd0;
          w[i]   = 3'sd0;
        end
      endcase
    end
    for (int i = 0; i <= N; i++)
      s[2*i +: 2] = digit_enc(w[i] + t[i]);
  end

endmodule

// File: rtl/online_ccm_pp_gen.sv
// One partial product: x shifted up by SHIFT digits, negated or zeroed by
// the coefficient digit.
module online_ccm_pp_gen
  import online_pkg::*;
#(
  parameter int STAGE = 4,
  parameter int SHIFT = 0,
  parameter int NOUT  = 14
) (
  input  logic [2*STAGE-1:0] x,
  input  logic [1:0]         dig,
  output logic [2*NOUT-1:0]  pp
);

  logic [2*NOUT-1:0] sh;

  // Negation is a plus/minus swap per digit; 11 coefficient digits give zero.
  always_comb begin
    sh = '0;
    sh[2*SHIFT +: 2*STAGE] = x;
    pp = '0;
    if (dig == DIG_POS) begin
      pp = sh;
    end else if (dig == DIG_NEG) begin
      for (int d = 0; d < NOUT; d++) pp[2*d +: 2] = {sh[2*d], sh[2*d+1]};
    end
  end

endmodule

// File: rtl/online_ccm_pipe.sv
// Pipelined signed-digit constant-coefficient multiplier with a runtime
// coefficient bank and a registered online adder tree.
module online_ccm_pipe
  import online_pkg::*;
#(
  parameter int STAGE = 4,
  parameter int CW    = 10,
  parameter int NCOEF = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [wl_digits(STAGE)-1:0]   x,
  input  logic [clog2(NCOEF)-1:0]       sel,
  input  logic                          coef_we,
  input  logic [clog2(NCOEF)-1:0]       coef_addr,
  input  logic [wl_digits(CW)-1:0]      coef_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [wl_out(STAGE, CW)-1:0]  y
);

  localparam int LV  = clog2(CW);
  localparam int ND0 = STAGE + CW;
  localparam int ND  = ND0 + LV;
  localparam int WD  = wl_digits(ND);

  logic                       en;
  logic [wl_digits(CW)-1:0]   bank_q [NCOEF];
  logic [wl_digits(CW)-1:0]   bank_d [NCOEF];
  logic [wl_digits(CW)-1:0]   coef_sel;
  logic [wl_digits(ND0)-1:0]  pp_w   [CW];
  logic [WD-1:0]              node_w [LV+1][CW];
  logic [WD-1:0]              lvl_q  [LV+1][CW];
  logic [WD-1:0]              lvl_d  [LV+1][CW];
  logic [LV:0]                vld_q;
  logic [LV:0]                vld_d;

  assign en        = out_ready | ~vld_q[LV];
  assign in_ready  = en;
  assign out_valid = vld_q[LV];
  assign y         = lvl_q[LV][0];
  assign coef_sel  = bank_q[sel];

  for (genvar j = 0; j < CW; j++) begin : g_pp
    online_ccm_pp_gen #(
      .STAGE(STAGE),
      .SHIFT(j),
      .NOUT (ND0)
    ) u_pp (
      .x  (x),
      .dig(coef_sel[2*j +: 2]),
      .pp (pp_w[j])
    );
    assign node_w[0][j] = WD'(pp_w[j]);
  end

  // Level k pairs operands of level k-1; an odd one out is carried up as is.
  for (genvar k = 1; k <= LV; k++) begin : g_lvl
    localparam int NI = ND0 + k - 1;
    localparam int CI = tree_cnt(CW, k - 1);
    localparam int CO = tree_cnt(CW, k);
    for (genvar i = 0; i < CW; i++) begin : g_node
      if (i < CO && 2*i + 1 < CI) begin : g_add
        logic [2*NI+1:0] sum;
        online_adder #(.N(NI)) u_add (
          .a(lvl_q[k-1][2*i][2*NI-1:0]),
          .b(lvl_q[k-1][2*i+1][2*NI-1:0]),
          .s(sum)
        );
        assign node_w[k][i] = WD'(sum);
      end else if (i < CO) begin : g_pass
        assign node_w[k][i] = lvl_q[k-1][2*i];
      end else begin : g_none
        assign node_w[k][i] = '0;
      end
    end
  end

  // Bank writes land regardless of pipeline stall; readers see the old value this cycle.
  always_comb begin
    bank_d = bank_q;
    if (coef_we) bank_d[coef_addr] = coef_data;
  end

  // Whole pipe, bubbles included, advances together or holds together.
  always_comb begin
    vld_d = en ? {vld_q[LV-1:0], in_valid} : vld_q;
    for (int k = 0; k <= LV; k++)
      for (int i = 0; i < CW; i++)
        lvl_d[k][i] = en ? node_w[k][i] : lvl_q[k][i];
  end

  // State registers; reset also clears the bank and blocks writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      lvl_q  <= '{default: '0};
      bank_q <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      lvl_q  <= lvl_d;
      bank_q <= bank_d;
    end
  end

endmodule

// File: tb/tb_online_ccm_pipe.sv
// Bench for online_ccm_pipe: directed samples push expected products into a
// queue; a monitor pops and compares on every output handshake.
module tb_online_ccm_pipe;
  import online_pkg::*;

  localparam int STAGE = 4;
  localparam int CW    = 10;
  localparam int NCOEF = 4;
  localparam int WL    = wl_out(STAGE, CW);
  localparam int LAT   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    x = '0;
  logic [1:0]    sel = '0;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_addr = '0;
  logic [19:0]   coef_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WL-1:0] y;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    longint val;
    int     due;
  } exp_t;
  exp_t exp_q[$];

  // Stream: x, sel, expected product (slots 214, -3, 1023, -1023).
  logic [7:0] sx [8] = '{8'h22, 8'h15, 8'hAA, 8'h55, 8'h22, 8'h15, 8'hAA, 8'hE7};
  logic [1:0] ss [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
  longint     se [8] = '{1070, 21, 15345, 15345, 5115, -1498, -45, -2046};

  online_ccm_pipe #(.STAGE(STAGE), .CW(CW), .NCOEF(NCOEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .sel      (sel),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint y_value(input logic [WL-1:0] v);
    longint r;
    r = 0;
    for (int i = 0; i < WL / 2; i++)
      r += (longint'(v[2*i+1]) - longint'(v[2*i])) * (longint'(1) <<< i);
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        chk("y_value", y_value(y), exp_q[0].val);
        if (out_ready) begin
          if (exp_q[0].due >= 0) chk("latency_cycle", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] xv, input logic [1:0] sv, input longint ev, input bit lat);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    x = xv;
    sel = sv;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp_t'{ev, lat ? cyc + LAT : -1});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [19:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", longint'(y), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    chk("to_csd_214", longint'(to_csd(214, CW)), 64'h20444);
    wr_coef(2'd0, 20'(to_csd(214, CW)));
    wr_coef(2'd1, 20'h00005);
    wr_coef(2'd2, 20'hAAAAA);
    wr_coef(2'd3, 20'h55555);

    // Two back-to-back samples with exact latency.
    send(8'h22, 2'd0, 1070, 1'b1);
    send(8'h15, 2'd1, 21, 1'b1);
    idle();
    drain();

    // Eight-sample stream with a three-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 8; i++) send(sx[i], ss[i], se[i], 1'b0);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Write to slot 0 in the same cycle as a sel=0 accept.
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 20'(to_csd(3, CW));
    send(8'h08, 2'd0, 428, 1'b1);
    coef_we = 1'b0;
    send(8'h08, 2'd0, 6, 1'b1);
    idle();
    drain();

    // Mid-flight reset, with a bank write attempted during reset.
    send(8'h22, 2'd0, 0, 1'b0);
    send(8'h22, 2'd0, 0, 1'b0);
    send(8'h22, 2'd0, 0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b1;
    coef_addr = 2'd1;
    coef_data = 20'h20444;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_y", longint'(y), 0);
    @(posedge clk);
    #1;
    send(8'h22, 2'd0, 0, 1'b1);
    send(8'h22, 2'd1, 0, 1'b1);
    idle();
    drain();
    repeat (8) @(posedge clk);
    #1;

    // Largest magnitudes: all +1 and all -1 digits.
    wr_coef(2'd0, 20'hAAAAA);
    wr_coef(2'd1, 20'h55555);
    send(8'hAA, 2'd0, 15345, 1'b1);
    send(8'h55, 2'd1, 15345, 1'b1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
